alu_sequencer: RTL and testbench

//  Control FSM sitting directly upstream of the ALU datapath (R0/R1 operand regs, R2 output latch, bus tri-state).

---
 rtl/alu_sequencer_if.sv | 41 ++++
 rtl/alu_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Handshake, bus-arbitration and ALU-control signals between the sequencer and its neighbours.
// master = sequencer side, slave = instruction source / bus arbiter / datapath side.
interface alu_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        instr_op;
    logic [ADDR_W-1:0] instr_src_a;
    logic [ADDR_W-1:0] instr_src_b;
    logic [ADDR_W-1:0] instr_dst;

    logic              bus_req;
    logic              bus_gnt;

    logic              rf_rd_en;
    logic [ADDR_W-1:0] rf_rd_addr;
    logic              rf_wr_en;
    logic [ADDR_W-1:0] rf_wr_addr;

    logic [2:0]        opCode;
    logic              ALUin1;
    logic              ALUin2;
    logic              ALU_outlach;
    logic              ALU_outEN;

    logic              done;
    logic              err;

    modport master (
        input  instr_valid, instr_op, instr_src_a, instr_src_b, instr_dst, bus_gnt,
        output instr_ready, bus_req, rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr,
               opCode, ALUin1, ALUin2, ALU_outlach, ALU_outEN, done, err
    );

    modport slave (
        output instr_valid, instr_op, instr_src_a, instr_src_b, instr_dst, bus_gnt,
        input  instr_ready, bus_req, rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr,
               opCode, ALUin1, ALUin2, ALU_outlach, ALU_outEN, done, err
    );
endinterface

// File: rtl/alu_sequencer.sv
// Control FSM ahead of the ALU datapath: loads operands over the shared bus, latches and writes back the result.
// Latency: 5 cycles accept-to-done for a binary op (4 for unary) with bus_gnt held 1; stalls while the bus is not granted.
// Backpressure: instr_ready only in IDLE; a bus_gnt drought of TIMEOUT cycles aborts the instruction with an err pulse.
module alu_sequencer #(
    parameter int       ADDR_W   = 4,
    parameter int       TIMEOUT  = 8,
    parameter bit [2:0] UNARY_OP = 3'b111,
    parameter bit       UNARY_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    alu_sequencer_if.master io
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_EXEC   = 3'd3,
        S_WRITE  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [2:0]        op_q;
    logic [ADDR_W-1:0] src_a_q;
    logic [ADDR_W-1:0] src_b_q;
    logic [ADDR_W-1:0] dst_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic              done_q;
    logic              err_q;

    logic              req_st;
    logic              gnt_ok;
    logic              bus_wait;
    logic              timeout_hit;
    logic              is_unary;

    // Grant only counts while we are actually requesting the bus.
    assign req_st   = (state == S_LOAD_A) || (state == S_LOAD_B) || (state == S_WRITE);
    assign gnt_ok   = req_st && io.bus_gnt;
    assign bus_wait = req_st && !io.bus_gnt;
    assign is_unary = UNARY_EN && (op_q == UNARY_OP);

    // The TIMEOUT-th consecutive ungranted cycle is the one that aborts.
    assign timeout_hit = (TIMEOUT > 0) && bus_wait && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (io.instr_valid) state_nxt = S_LOAD_A;
            end
            S_LOAD_A: begin
                if (timeout_hit)  state_nxt = S_IDLE;
                else if (gnt_ok)  state_nxt = is_unary ? S_EXEC : S_LOAD_B;
            end
            S_LOAD_B: begin
                if (timeout_hit)  state_nxt = S_IDLE;
                else if (gnt_ok)  state_nxt = S_EXEC;
            end
            S_EXEC: begin
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (timeout_hit || gnt_ok) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        io.instr_ready = 1'b0;
        io.bus_req     = 1'b0;
        io.rf_rd_en    = 1'b0;
        io.rf_rd_addr  = '0;
        io.rf_wr_en    = 1'b0;
        io.rf_wr_addr  = '0;
        io.ALUin1      = 1'b0;
        io.ALUin2      = 1'b0;
        io.ALU_outlach = 1'b0;
        io.ALU_outEN   = 1'b0;
        case (state)
            S_IDLE: begin
                io.instr_ready = rst;
            end
            S_LOAD_A: begin
                io.bus_req    = 1'b1;
                io.rf_rd_addr = src_a_q;
                io.rf_rd_en   = io.bus_gnt;
                io.ALUin1     = io.bus_gnt;
            end
            S_LOAD_B: begin
                io.bus_req    = 1'b1;
                io.rf_rd_addr = src_b_q;
                io.rf_rd_en   = io.bus_gnt;
                io.ALUin2     = io.bus_gnt;
            end
            S_EXEC: begin
                io.ALU_outlach = 1'b1;
            end
            S_WRITE: begin
                io.bus_req    = 1'b1;
                io.rf_wr_addr = dst_q;
                io.rf_wr_en   = io.bus_gnt;
                io.ALU_outEN  = io.bus_gnt;
            end
            default: begin
                io.instr_ready = 1'b0;
            end
        endcase
    end

    assign io.opCode = op_q;
    assign io.done   = done_q;
    assign io.err    = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
        end else if (state == S_IDLE && io.instr_valid) begin
            op_q    <= io.instr_op;
            src_a_q <= io.instr_src_a;
            src_b_q <= io.instr_src_b;
            dst_q   <= io.instr_dst;
        end
    end

    // Counts the current run of ungranted request cycles within one state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (gnt_ok || state_nxt != state) begin
            wait_cnt <= '0;
        end else if (bus_wait) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= (state == S_WRITE) && gnt_ok;
            err_q  <= timeout_hit;
        end
    end

    a_no_bus_fight: assert property (@(posedge clk) disable iff (!rst)
        !(io.rf_rd_en && io.ALU_outEN));

    a_strobe_needs_gnt: assert property (@(posedge clk) disable iff (!rst)
        (io.ALUin1 || io.ALUin2 || io.rf_rd_en || io.rf_wr_en) |-> io.bus_gnt);

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized and directed bench for alu_sequencer against a step-queue reference model.
// The model holds each accepted instruction as a list of pending bus/exec steps.
module tb_alu_sequencer;

    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    alu_sequencer #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT),
        .UNARY_OP(3'b111),
        .UNARY_EN(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef enum int {ST_RD_A, ST_RD_B, ST_EXEC, ST_WR} step_t;
    step_t             m_steps[$];
    logic [2:0]        m_op;
    logic [ADDR_W-1:0] m_a, m_b, m_d;
    int                m_wait;
    logic              m_done, m_err;
    int                m_n_done, m_n_err;

    int acc_q[$], done_q[$], err_q[$];
    int n_in2, n_wr;

    function automatic logic [9:0] obs();
        return {bus.instr_ready, bus.bus_req, bus.rf_rd_en, bus.rf_wr_en, bus.ALUin1,
                bus.ALUin2, bus.ALU_outlach, bus.ALU_outEN, bus.done, bus.err};
    endfunction

    function automatic logic [9:0] model_out();
        logic  g, idle, req;
        step_t h;
        g    = bus.bus_gnt;
        idle = (m_steps.size() == 0);
        h    = idle ? ST_EXEC : m_steps[0];
        req  = !idle && (h != ST_EXEC);
        return {idle, req,
                !idle && (h == ST_RD_A || h == ST_RD_B) && g,
                !idle && h == ST_WR && g,
                !idle && h == ST_RD_A && g,
                !idle && h == ST_RD_B && g,
                !idle && h == ST_EXEC,
                !idle && h == ST_WR && g,
                m_done, m_err};
    endfunction

    task automatic model_step();
        logic nd, ne;
        nd = 1'b0;
        ne = 1'b0;
        if (m_steps.size() == 0) begin
            if (bus.instr_valid) begin
                m_op = bus.instr_op;
                m_a  = bus.instr_src_a;
                m_b  = bus.instr_src_b;
                m_d  = bus.instr_dst;
                m_steps.push_back(ST_RD_A);
                if (m_op != 3'b111) m_steps.push_back(ST_RD_B);
                m_steps.push_back(ST_EXEC);
                m_steps.push_back(ST_WR);
                m_wait = 0;
            end
        end else if (m_steps[0] == ST_EXEC) begin
            void'(m_steps.pop_front());
            m_wait = 0;
        end else if (bus.bus_gnt) begin
            if (m_steps[0] == ST_WR) nd = 1'b1;
            void'(m_steps.pop_front());
            m_wait = 0;
        end else begin
            m_wait++;
            if (TIMEOUT > 0 && m_wait == TIMEOUT) begin
                m_steps.delete();
                m_wait = 0;
                ne = 1'b1;
            end
        end
        m_done = nd;
        m_err  = ne;
        if (nd) m_n_done++;
        if (ne) m_n_err++;
    endtask

    task automatic model_reset();
        m_steps.delete();
        m_wait = 0;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_op   = '0;
    endtask

    task automatic clr();
        acc_q.delete();
        done_q.delete();
        err_q.delete();
        n_in2 = 0;
        n_wr  = 0;
    endtask

    // One clock: compare at negedge, advance the model, return just after posedge.
    task automatic cycle();
        @(negedge clk);
        chk("strobes", obs(), model_out());
        if (m_steps.size() != 0) begin
            chk("opcode", bus.opCode, m_op);
            case (m_steps[0])
                ST_RD_A: chk("rd_addr_a", bus.rf_rd_addr, m_a);
                ST_RD_B: chk("rd_addr_b", bus.rf_rd_addr, m_b);
                ST_WR:   chk("wr_addr", bus.rf_wr_addr, m_d);
                default: ;
            endcase
        end
        if (bus.instr_ready && bus.instr_valid) acc_q.push_back(cyc);
        if (bus.done) done_q.push_back(cyc);
        if (bus.err) err_q.push_back(cyc);
        if (bus.ALUin2) n_in2++;
        if (bus.rf_wr_en) n_wr++;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until(input string tag, input int max);
        int sd, se;
        sd = done_q.size();
        se = err_q.size();
        for (int i = 0; i < max; i++) begin
            cycle();
            if (done_q.size() > sd || err_q.size() > se) return;
        end
        chk({tag, "_wait_bound"}, done_q.size() + err_q.size(), sd + se + 1);
    endtask

    function automatic int last(input int q[$]);
        return (q.size() != 0) ? q[q.size()-1] : -1000;
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input int a, input int b, input int d);
        bus.instr_valid = v;
        bus.instr_op    = op;
        bus.instr_src_a = ADDR_W'(a);
        bus.instr_src_b = ADDR_W'(b);
        bus.instr_dst   = ADDR_W'(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        m_n_done = 0;
        m_n_err  = 0;
        drive(1'b0, 3'b000, 0, 0, 0);
        bus.bus_gnt = 1'b0;
        clr();

        // Power-on reset state
        repeat (2) @(posedge clk);
        #1;
        chk("por_outputs", obs(), 10'b0);
        chk("por_opcode", bus.opCode, 3'b000);
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Binary op, grant always
        clr();
        bus.bus_gnt = 1'b1;
        drive(1'b1, 3'b001, 2, 5, 7);
        cycle();
        drive(1'b0, 3'b000, 0, 0, 0);
        run_until("bin", 10);
        chk("bin_latency", last(done_q) - last(acc_q), 5);
        chk("bin_n_in2", n_in2, 1);
        chk("bin_n_wr", n_wr, 1);
        cycle();

        // Unary op skips operand B
        clr();
        drive(1'b1, 3'b111, 3, 9, 1);
        cycle();
        drive(1'b0, 3'b000, 0, 0, 0);
        run_until("unary", 10);
        chk("unary_latency", last(done_q) - last(acc_q), 4);
        chk("unary_n_in2", n_in2, 0);

        // Grant stall of 3 cycles in LOAD_A
        clr();
        bus.bus_gnt = 1'b0;
        drive(1'b1, 3'b001, 4, 6, 8);
        cycle();
        drive(1'b0, 3'b000, 0, 0, 0);
        repeat (3) cycle();
        bus.bus_gnt = 1'b1;
        run_until("stall", 12);
        chk("stall_latency", last(done_q) - last(acc_q), 8);

        // Timeout while waiting to write back
        clr();
        bus.bus_gnt = 1'b1;
        drive(1'b1, 3'b011, 1, 2, 3);
        cycle();
        drive(1'b0, 3'b000, 0, 0, 0);
        repeat (3) cycle();
        bus.bus_gnt = 1'b0;
        run_until("timeout", 20);
        chk("timeout_latency", last(err_q) - last(acc_q), 12);
        chk("timeout_n_wr", n_wr, 0);
        chk("timeout_n_done", done_q.size(), 0);
        chk("timeout_n_err", err_q.size(), 1);
        cycle();

        // Back-to-back with instr_valid held high
        clr();
        bus.bus_gnt = 1'b1;
        drive(1'b1, 3'b010, 1, 3, 4);
        cycle();
        drive(1'b1, 3'b100, 6, 8, 9);
        for (int i = 0; i < 20 && acc_q.size() < 2; i++) cycle();
        drive(1'b0, 3'b000, 0, 0, 0);
        run_until("b2b", 10);
        chk("b2b_n_done", done_q.size(), 2);
        chk("b2b_n_acc", acc_q.size(), 2);
        if (done_q.size() == 2 && acc_q.size() == 2) begin
            chk("b2b_accept_in_done", acc_q[1], done_q[0]);
            chk("b2b_spacing", done_q[1] - done_q[0], 5);
        end
        cycle();

        // Reset asserted mid-LOAD_B with grant high
        clr();
        bus.bus_gnt = 1'b1;
        drive(1'b1, 3'b001, 2, 5, 7);
        cycle();
        drive(1'b0, 3'b000, 0, 0, 0);
        cycle();
        #2 rst = 1'b0;
        #1;
        chk("rst_strobes", obs(), 10'b0);
        @(negedge clk);
        model_reset();
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        chk("rst_release_ready", bus.instr_ready, 1'b1);
        chk("rst_release_done_err", {bus.done, bus.err}, 2'b00);
        cycle();
        chk("rst_no_pulse", done_q.size() + err_q.size(), 0);

        // Randomized traffic with periodic grant droughts
        clr();
        m_n_done = 0;
        m_n_err  = 0;
        for (int i = 0; i < 500; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)));
            if (((i / 40) % 4) == 3) bus.bus_gnt = ($urandom_range(0, 15) == 0);
            else                     bus.bus_gnt = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drive(1'b0, 3'b000, 0, 0, 0);
        bus.bus_gnt = 1'b1;
        repeat (8) cycle();
        chk("rand_n_done", done_q.size(), m_n_done);
        chk("rand_n_err", err_q.size(), m_n_err);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
